// File: rtl/pipo_univ_if.sv
// Bus bundle for pipo_univ: operation/data inputs and register/status outputs.
// master drives op/din/sin and observes the register; slave is the register side.
// Ports: op[2:0], din[WIDTH-1:0], sin -> slave; dout, zero, ovf, busy, done -> master.
interface pipo_univ_if #(
   parameter int WIDTH = 16
);
   logic [2:0]       op;
   logic [WIDTH-1:0] din;
   logic             sin;
   logic [WIDTH-1:0] dout;
   logic             zero;
   logic             ovf;
   logic             busy;
   logic             done;

   modport master (
      output op, din, sin,
      input  dout, zero, ovf, busy, done
   );

   modport slave (
      input  op, din, sin,
      output dout, zero, ovf, busy, done
   );
endinterface

// File: rtl/pipo_univ.sv
// Universal parallel-in/parallel-out register: load, shift, inc/dec, countdown.
// Ports: clk, clr (async active-high reset), bus (pipo_univ_if.slave).
// Every op takes effect on the edge that samples it; countdown from N stays N cycles in RUN.
module pipo_univ #(
   parameter int               WIDTH   = 16,
   parameter logic [WIDTH-1:0] RST_VAL = '0,
   parameter bit               SAT     = 1'b0
) (
   input logic        clk,
   input logic        clr,
   pipo_univ_if.slave bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [2:0] OP_HOLD  = 3'b000;
   localparam logic [2:0] OP_LOAD  = 3'b001;
   localparam logic [2:0] OP_SHL   = 3'b010;
   localparam logic [2:0] OP_SHR   = 3'b011;
   localparam logic [2:0] OP_INC   = 3'b100;
   localparam logic [2:0] OP_DEC   = 3'b101;
   localparam logic [2:0] OP_START = 3'b110;
   localparam logic [2:0] OP_CLR   = 3'b111;

   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

   logic [1:0]       state, state_nxt;
   logic [WIDTH-1:0] dout_q, dout_nxt;
   logic             ovf_q, ovf_nxt;

   always_comb begin
      state_nxt = state;
      dout_nxt  = dout_q;
      ovf_nxt   = ovf_q;
      case (state)
         S_IDLE: begin
            case (bus.op)
               OP_HOLD: ;
               OP_LOAD: begin
                  dout_nxt = bus.din;
                  ovf_nxt  = 1'b0;
               end
               OP_SHL: dout_nxt = {dout_q[WIDTH-2:0], bus.sin};
               OP_SHR: dout_nxt = {bus.sin, dout_q[WIDTH-1:1]};
               OP_INC: begin
                  if (dout_q == ALL_ONES) begin
                     ovf_nxt  = 1'b1;
                     dout_nxt = SAT ? ALL_ONES : '0;
                  end else begin
                     dout_nxt = dout_q + ONE;
                  end
               end
               OP_DEC: begin
                  if (dout_q == '0) begin
                     ovf_nxt  = 1'b1;
                     dout_nxt = SAT ? '0 : ALL_ONES;
                  end else begin
                     dout_nxt = dout_q - ONE;
                  end
               end
               OP_START: begin
                  dout_nxt  = bus.din;
                  ovf_nxt   = 1'b0;
                  // A zero start value has nothing to count, so go straight to DONE.
                  state_nxt = (bus.din != '0) ? S_RUN : S_DONE;
               end
               OP_CLR: begin
                  dout_nxt = RST_VAL;
                  ovf_nxt  = 1'b0;
               end
            endcase
         end
         S_RUN: begin
            if (bus.op == OP_CLR) begin
               dout_nxt  = RST_VAL;
               ovf_nxt   = 1'b0;
               state_nxt = S_IDLE;
            end else begin
               // RUN is only entered with dout != 0 and left when it reaches 0,
               // so this decrement can never underflow or touch ovf.
               dout_nxt = dout_q - ONE;
               if (dout_q == ONE) begin
                  state_nxt = S_DONE;
               end
            end
         end
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state  <= S_IDLE;
         dout_q <= RST_VAL;
         ovf_q  <= 1'b0;
      end else begin
         state  <= state_nxt;
         dout_q <= dout_nxt;
         ovf_q  <= ovf_nxt;
      end
   end

   // Status flags decode registered state only, so op changes cannot glitch them.
   assign bus.dout = dout_q;
   assign bus.zero = (dout_q == '0);
   assign bus.ovf  = ovf_q;
   assign bus.busy = (state == S_RUN);
   assign bus.done = (state == S_DONE);

endmodule

// File: doc/pipo_univ.md
PIPO_UNIV -- requirements
Module: pipo_univ

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, data width in bits (legal range 2..64).
REQ-002 SHALL provide parameter RST_VAL, default 0, value loaded into dout on reset and sync clear.
REQ-003 SHALL provide parameter SAT, default 0, where 1 = saturating inc/dec and 0 = wrap-around inc/dec.
REQ-004 SHALL provide port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL provide port clr  input  1  reset, asynchronous, active-high.
REQ-006 SHALL provide port op  input  3  operation select, sampled every rising edge.
REQ-007 SHALL provide port din  input  WIDTH  parallel load / countdown start value.
REQ-008 SHALL provide port sin  input  1  serial bit entering on shift operations.
REQ-009 SHALL provide port dout  output  WIDTH  register contents.
REQ-010 SHALL provide port zero  output  1  high exactly when dout == 0 (combinational from dout).
REQ-011 SHALL provide port ovf  output  1  sticky overflow flag (inc past max, or dec below 0).
REQ-012 SHALL provide port busy  output  1  high while the countdown FSM is in RUN.
REQ-013 SHALL provide port done  output  1  one-cycle pulse when a countdown completes.

Function
REQ-014 SHALL decode op in IDLE: 000 hold; 001 load din; 010 shift left {dout[W-2:0],sin}; 011 shift right {sin,dout[W-1:1]}; 100 increment; 101 decrement; 110 start countdown; 111 sync clear.
REQ-015 SHALL make every IDLE op take effect on the edge that samples it (latency 1 cycle, dout updated after that edge).
REQ-016 SHALL, on increment at all-ones: SAT=1 hold all-ones, SAT=0 wrap to 0; ovf set in both cases.
REQ-017 SHALL, on decrement at 0: SAT=1 hold 0, SAT=0 wrap to all-ones; ovf set in both cases.
REQ-018 SHALL clear ovf on load (001), start (110) and sync clear (111); shifts, hold and in-range inc/dec leave ovf unchanged.
REQ-019 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-020 SHALL, on op 110 in IDLE: dout <= din, ovf <= 0; go to RUN if din != 0, else to DONE.
REQ-021 SHALL, in RUN: decrement dout by 1 each cycle; when dout == 1 the edge writes 0 and moves to DONE; countdown from N spends exactly N cycles in RUN.
REQ-022 SHALL, in RUN: ignore all ops except 111; op 111 sets dout <= RST_VAL, ovf <= 0, state IDLE, and no done pulse follows.
REQ-023 SHALL, in DONE: assert done for exactly one cycle, hold dout (0), ignore op, return to IDLE on the next edge.
REQ-024 SHALL drive busy = 1 only in RUN and done = 1 only in DONE, both as registered state decodes (no glitches from op).
REQ-025 SHALL never set ovf during a countdown (RUN never decrements below 0).

Reset
REQ-026 SHALL, while clr = 1, force dout = RST_VAL, ovf = 0, state IDLE, busy = 0, done = 0, immediately and independent of clk.
REQ-027 SHALL abort an in-progress countdown on clr with no done pulse; the first op sampled after clr falls executes from IDLE.
REQ-028 SHALL give clr priority over every op including 111.

Verification
REQ-029 SHALL cover: WIDTH=16, op=001 din=0x1234, then op=010 sin=1 -> dout 0x1234 then 0x2469; op=011 sin=0 -> 0x1234.
REQ-030 SHALL cover: SAT=0, load 0xFFFF, op=100 -> dout 0x0000, ovf=1, zero=1; op=001 din=5 -> ovf=0.
REQ-031 SHALL cover: SAT=1, load 0x0000, op=101 -> dout stays 0x0000, ovf=1; repeat with SAT=1 at 0xFFFF inc -> 0xFFFF, ovf=1.
REQ-032 SHALL cover: op=110 din=3 -> busy high 3 cycles (dout 3,2,1), then dout=0 with done high 1 cycle, then IDLE; op=101 driven during RUN has no effect.
REQ-033 SHALL cover: op=110 din=0 -> no busy, done high on the cycle after start, dout=0.
REQ-034 SHALL cover: countdown from 10 with clr pulsed mid-RUN between edges -> dout = RST_VAL at once, busy=0, no done; a second run aborted by op=111 behaves the same.
